pixel_burst_bridge: RTL and testbench



---
 rtl/pixel_burst_bridge_if.sv | 24 ++
 rtl/pixel_burst_bridge.sv | 142 ++++++++++++++
 tb/tb_pixel_burst_bridge.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_burst_bridge_if.sv
// Handshake bundle between the upstream count-FIFO, the bridge and the downstream consumer.
interface pixel_burst_bridge_if #(
  parameter int unsigned DATA_WIDTH  = 17,
  parameter int unsigned COUNT_WIDTH = 10
);
  logic [COUNT_WIDTH-1:0] src_count;
  logic                   src_rd_en;
  logic [DATA_WIDTH-1:0]  src_data;
  logic                   dst_valid;
  logic                   dst_ready;
  logic [DATA_WIDTH-1:0]  dst_data;

  // Bridge side: issues reads upstream, presents pixels downstream.
  modport master (
    input  src_count, src_data, dst_ready,
    output src_rd_en, dst_valid, dst_data
  );

  // Environment side: upstream FIFO plus downstream consumer.
  modport slave (
    output src_count, src_data, dst_ready,
    input  src_rd_en, dst_valid, dst_data
  );
endinterface

// File: rtl/pixel_burst_bridge.sv
// Burst reader from a count-qualified FIFO into a small circular buffer feeding a
// valid/ready consumer, with optional per-burst 2x horizontal pixel duplication.
module pixel_burst_bridge #(
  parameter int unsigned DATA_WIDTH  = 17,
  parameter int unsigned COUNT_WIDTH = 10,
  parameter int unsigned DEPTH_WIDTH = 4,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned THRESHOLD   = 5
) (
  input  logic                 clk_w,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 mode,
  pixel_burst_bridge_if.master bus,
  output logic [DEPTH_WIDTH:0] buf_count,
  output logic                 burst_done
);

  localparam int unsigned DEPTH   = 1 << DEPTH_WIDTH;
  localparam int unsigned CNT_W   = DEPTH_WIDTH + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BURST, LAND} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_beat, w_beat_nxt;
  logic                 r_burst_mode, w_burst_mode_nxt;
  logic                 r_rd_en, w_rd_en_nxt;
  logic                 r_done, w_done_nxt;

  logic                 r_rd_vld;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_phase;

  logic [CNT_W-1:0]     w_free;
  logic                 w_start, w_wr, w_hs, w_pop;
  logic [ENTRY_W-1:0]   w_head;

  assign w_free  = CNT_W'(DEPTH) - r_count;
  assign w_start = (bus.src_count > COUNT_WIDTH'(THRESHOLD)) &&
                   (bus.src_count >= COUNT_WIDTH'(BURST_LEN)) &&
                   (w_free >= CNT_W'(BURST_LEN)) && !flush;

  assign w_head = r_mem[r_rptr];
  assign w_wr   = r_rd_vld && !flush;
  assign w_hs   = (r_count != '0) && bus.dst_ready;
  // A duplicate-tagged head only leaves on its second handshake.
  assign w_pop  = w_hs && (!w_head[DATA_WIDTH] || r_phase);

  // FSM state plus the registered read strobe, burst counter and done pulse.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_burst_mode <= 1'b0;
      r_rd_en      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      r_burst_mode <= w_burst_mode_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state: start a burst when upstream has enough and the buffer has room.
  always_comb begin
    w_state_nxt      = r_state;
    w_beat_nxt       = r_beat;
    w_burst_mode_nxt = r_burst_mode;
    w_rd_en_nxt      = 1'b0;
    w_done_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt      = BURST;
          w_beat_nxt       = '0;
          w_burst_mode_nxt = mode;
          w_rd_en_nxt      = 1'b1;
        end
      end
      BURST: begin
        if (r_beat == CNT_W'(BURST_LEN - 1)) begin
          w_state_nxt = LAND;
          w_done_nxt  = 1'b1;
        end else begin
          w_beat_nxt  = r_beat + CNT_W'(1);
          w_rd_en_nxt = 1'b1;
        end
      end
      LAND:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_rd_en_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  // Buffer: capture returning reads at the tail, pop/duplicate at the head.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_phase  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      // Reads issued this cycle return next cycle and must be dropped.
      r_rd_vld <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_rd_vld <= r_rd_en;
      if (w_wr) begin
        r_mem[r_wptr] <= {r_burst_mode, bus.src_data};
        r_wptr        <= r_wptr + DEPTH_WIDTH'(1);
      end
      if (w_pop) r_rptr <= r_rptr + DEPTH_WIDTH'(1);
      if (w_hs && w_head[DATA_WIDTH]) r_phase <= !r_phase;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.src_rd_en = r_rd_en;
  assign bus.dst_valid = (r_count != '0);
  assign bus.dst_data  = w_head[DATA_WIDTH-1:0];
  assign buf_count     = r_count;
  assign burst_done    = r_done;

endmodule

// File: tb/tb_pixel_burst_bridge.sv
// Directed bench for pixel_burst_bridge: a BURST_LEN=8 instance for most scenarios
// and a BURST_LEN=4 instance for the threshold boundary.
module tb_pixel_burst_bridge;

  localparam int unsigned DW = 17;
  localparam int unsigned CW = 10;

  logic clk_w = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic mode  = 1'b0;

  always #5 clk_w = ~clk_w;

  pixel_burst_bridge_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus  ();
  pixel_burst_bridge_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus4 ();

  logic [4:0] buf_count, buf_count4;
  logic       burst_done, burst_done4;

  pixel_burst_bridge #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH_WIDTH(4),
                       .BURST_LEN(8), .THRESHOLD(5)) dut (
    .clk_w(clk_w), .rst_n(rst_n), .flush(flush), .mode(mode), .bus(bus),
    .buf_count(buf_count), .burst_done(burst_done));

  pixel_burst_bridge #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH_WIDTH(4),
                       .BURST_LEN(4), .THRESHOLD(5)) dut4 (
    .clk_w(clk_w), .rst_n(rst_n), .flush(flush), .mode(mode), .bus(bus4),
    .buf_count(buf_count4), .burst_done(burst_done4));

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream FIFO models: one-cycle read latency, incrementing pixel values.
  logic [DW-1:0] pix  = DW'(1);
  logic [DW-1:0] pix4 = DW'(1);
  always @(posedge clk_w) if (bus.src_rd_en) begin bus.src_data <= pix; pix <= pix + DW'(1); end
  always @(posedge clk_w) if (bus4.src_rd_en) begin bus4.src_data <= pix4; pix4 <= pix4 + DW'(1); end

  // Observers: accepted beats, read strobes, done pulses, peak occupancy, hold-under-stall.
  logic [DW-1:0] outq[$];
  int unsigned   rd_total = 0, rd4_total = 0, done_total = 0, hold_err = 0;
  logic [4:0]    max_count = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(posedge clk_w) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.dst_valid && bus.dst_ready) outq.push_back(bus.dst_data);
      if (bus.src_rd_en) rd_total++;
      if (bus4.src_rd_en) rd4_total++;
      if (burst_done) done_total++;
      if (buf_count > max_count) max_count = buf_count;
      if (prev_stall && (!bus.dst_valid || bus.dst_data !== prev_data)) hold_err++;
      prev_stall = bus.dst_valid && !bus.dst_ready;
      prev_data  = bus.dst_data;
    end
  end

  task automatic test_reset();
    bus.src_count = '0; bus.dst_ready = 1'b0;
    bus4.src_count = '0; bus4.dst_ready = 1'b1;
    repeat (2) @(negedge clk_w);
    n_checks++; if (bus.src_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.src_rd_en); end
    n_checks++; if (bus.dst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dst_valid: got %b want 0", bus.dst_valid); end
    n_checks++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL reset_buf_count: got %0d want 0", buf_count); end
    n_checks++; if (burst_done !== 1'b0) begin n_fail++; $display("FAIL reset_burst_done: got %b want 0", burst_done); end
    n_checks++; if (bus.dst_data !== DW'(0)) begin n_fail++; $display("FAIL reset_dst_data: got %h want 0", bus.dst_data); end
    rst_n = 1'b1;
    @(negedge clk_w);
  endtask

  task automatic test_passthrough();
    logic [12:1] rd_bits, done_bits, vld_bits;
    logic [DW-1:0] base;
    int unsigned d0;
    base = pix; d0 = done_total;
    mode = 1'b0; bus.dst_ready = 1'b1; outq.delete();
    bus.src_count = CW'(20);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_w);
      if (k == 1) bus.src_count = '0;
      rd_bits[k] = bus.src_rd_en; done_bits[k] = burst_done; vld_bits[k] = bus.dst_valid;
    end
    repeat (4) @(negedge clk_w);
    n_checks++; if (rd_bits !== 12'h0FF) begin n_fail++; $display("FAIL pt_rd_en_window: got %h want 0ff", rd_bits); end
    n_checks++; if (done_bits !== 12'h100) begin n_fail++; $display("FAIL pt_done_pulse: got %h want 100", done_bits); end
    n_checks++; if (vld_bits !== 12'h3FC) begin n_fail++; $display("FAIL pt_valid_window: got %h want 3fc", vld_bits); end
    n_checks++; if (outq.size() !== 8) begin n_fail++; $display("FAIL pt_beats: got %0d want 8", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      n_checks++; if (outq[i] !== DW'(base + DW'(i))) begin n_fail++; $display("FAIL pt_data[%0d]: got %h want %h", i, outq[i], DW'(base + DW'(i))); end
    end
    n_checks++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL pt_buf_empty: got %0d want 0", buf_count); end
    n_checks++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL pt_done_count: got %0d want 1", done_total - d0); end
  endtask

  task automatic test_threshold();
    int unsigned r0;
    r0 = rd4_total;
    bus4.src_count = CW'(5);
    repeat (6) @(negedge clk_w);
    n_checks++; if (rd4_total !== r0) begin n_fail++; $display("FAIL thr_no_read_at_5: got %0d reads want 0", rd4_total - r0); end
    bus4.src_count = CW'(6);
    @(negedge clk_w);
    bus4.src_count = '0;
    n_checks++; if (bus4.src_rd_en !== 1'b1) begin n_fail++; $display("FAIL thr_start_at_6: got %b want 1", bus4.src_rd_en); end
    repeat (10) @(negedge clk_w);
    n_checks++; if (rd4_total - r0 !== 4) begin n_fail++; $display("FAIL thr_burst_len: got %0d want 4", rd4_total - r0); end
    n_checks++; if (buf_count4 !== 5'd0) begin n_fail++; $display("FAIL thr_drained: got %0d want 0", buf_count4); end
  endtask

  task automatic test_duplicate();
    logic [DW-1:0] base;
    int unsigned budget;
    base = pix; budget = 0; hold_err = 0; outq.delete();
    mode = 1'b1; bus.dst_ready = 1'b0;
    bus.src_count = CW'(20);
    @(negedge clk_w);
    bus.src_count = '0;
    mode = 1'b0;
    while (outq.size() < 16 && budget < 100) begin
      @(negedge clk_w);
      bus.dst_ready = ~bus.dst_ready;
      budget++;
    end
    bus.dst_ready = 1'b1;
    repeat (6) @(negedge clk_w);
    n_checks++; if (outq.size() !== 16) begin n_fail++; $display("FAIL dup_beats: got %0d want 16", outq.size()); end
    for (int i = 0; i < 16 && i < outq.size(); i++) begin
      n_checks++; if (outq[i] !== DW'(base + DW'(i / 2))) begin n_fail++; $display("FAIL dup_data[%0d]: got %h want %h", i, outq[i], DW'(base + DW'(i / 2))); end
    end
    n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL dup_hold_under_stall: got %0d want 0", hold_err); end
    n_checks++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL dup_drained: got %0d want 0", buf_count); end
  endtask

  task automatic test_full();
    logic [DW-1:0] base;
    int unsigned r0;
    logic ok;
    base = pix; r0 = rd_total; max_count = '0; outq.delete();
    mode = 1'b0; bus.dst_ready = 1'b0;
    bus.src_count = CW'(100);
    repeat (40) @(negedge clk_w);
    n_checks++; if (buf_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", buf_count); end
    n_checks++; if (rd_total - r0 !== 16) begin n_fail++; $display("FAIL full_two_bursts: got %0d reads want 16", rd_total - r0); end
    n_checks++; if (bus.dst_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", bus.dst_valid); end
    n_checks++; if (bus.dst_data !== base) begin n_fail++; $display("FAIL full_head: got %h want %h", bus.dst_data, base); end
    bus.dst_ready = 1'b1;
    repeat (14) @(negedge clk_w);
    n_checks++; if ((rd_total - r0 > 16) !== 1'b1) begin n_fail++; $display("FAIL full_refill: got %0d reads want >16", rd_total - r0); end
    bus.src_count = '0;
    repeat (40) @(negedge clk_w);
    n_checks++; if (outq.size() !== int'(rd_total - r0)) begin n_fail++; $display("FAIL full_all_out: got %0d want %0d", outq.size(), rd_total - r0); end
    ok = 1'b1;
    for (int i = 0; i < outq.size(); i++) if (outq[i] !== DW'(base + DW'(i))) ok = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_order: got out-of-order data want %h upward", base); end
    n_checks++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", buf_count); end
    n_checks++; if (max_count !== 5'd16) begin n_fail++; $display("FAIL full_peak: got %0d want 16", max_count); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] base;
    int unsigned d0;
    base = pix; d0 = done_total;
    bus.dst_ready = 1'b0; mode = 1'b0;
    bus.src_count = CW'(20);
    @(negedge clk_w);
    bus.src_count = '0;
    @(negedge clk_w);
    @(negedge clk_w);
    n_checks++; if (bus.src_rd_en !== 1'b1) begin n_fail++; $display("FAIL fl_third_read: got %b want 1", bus.src_rd_en); end
    n_checks++; if (buf_count !== 5'd1) begin n_fail++; $display("FAIL fl_pre_count: got %0d want 1", buf_count); end
    flush = 1'b1;
    @(negedge clk_w);
    flush = 1'b0;
    n_checks++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL fl_count: got %0d want 0", buf_count); end
    n_checks++; if (bus.dst_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", bus.dst_valid); end
    n_checks++; if (bus.src_rd_en !== 1'b0) begin n_fail++; $display("FAIL fl_rd_en: got %b want 0", bus.src_rd_en); end
    repeat (6) @(negedge clk_w);
    n_checks++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL fl_inflight_dropped: got %0d want 0", buf_count); end
    n_checks++; if (done_total !== d0) begin n_fail++; $display("FAIL fl_no_done: got %0d want %0d", done_total, d0); end
    n_checks++; if (pix - base !== DW'(3)) begin n_fail++; $display("FAIL fl_reads_issued: got %0d want 3", pix - base); end
    outq.delete(); bus.dst_ready = 1'b1;
    bus.src_count = CW'(20);
    @(negedge clk_w);
    bus.src_count = '0;
    repeat (20) @(negedge clk_w);
    n_checks++; if (outq.size() !== 8) begin n_fail++; $display("FAIL fl_resume_beats: got %0d want 8", outq.size()); end
    if (outq.size() == 8) begin
      n_checks++; if (outq[0] !== DW'(base + DW'(3))) begin n_fail++; $display("FAIL fl_resume_first: got %h want %h", outq[0], DW'(base + DW'(3))); end
      n_checks++; if (outq[7] !== DW'(base + DW'(10))) begin n_fail++; $display("FAIL fl_resume_last: got %h want %h", outq[7], DW'(base + DW'(10))); end
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] base;
    bus.dst_ready = 1'b1; mode = 1'b0;
    bus.src_count = CW'(20);
    @(negedge clk_w);
    bus.src_count = '0;
    @(negedge clk_w);
    @(negedge clk_w);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.src_rd_en !== 1'b0) begin n_fail++; $display("FAIL ar_rd_en: got %b want 0", bus.src_rd_en); end
    n_checks++; if (bus.dst_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", bus.dst_valid); end
    n_checks++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", buf_count); end
    n_checks++; if (burst_done !== 1'b0) begin n_fail++; $display("FAIL ar_done: got %b want 0", burst_done); end
    n_checks++; if (bus.dst_data !== DW'(0)) begin n_fail++; $display("FAIL ar_data: got %h want 0", bus.dst_data); end
    @(negedge clk_w);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_w);
    base = pix; outq.delete();
    bus.src_count = CW'(20);
    @(negedge clk_w);
    bus.src_count = '0;
    repeat (20) @(negedge clk_w);
    n_checks++; if (outq.size() !== 8) begin n_fail++; $display("FAIL ar_resume_beats: got %0d want 8", outq.size()); end
    if (outq.size() == 8) begin
      n_checks++; if (outq[0] !== base) begin n_fail++; $display("FAIL ar_resume_first: got %h want %h", outq[0], base); end
      n_checks++; if (outq[7] !== DW'(base + DW'(7))) begin n_fail++; $display("FAIL ar_resume_last: got %h want %h", outq[7], DW'(base + DW'(7))); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_threshold();
    test_duplicate();
    test_full();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
